// File: rtl/gate_sensor_fsm.sv
// rtl/gate_sensor_fsm.sv - two-beam gate passage FSM emitting entry/exit/reject/error pulses
// Optional per-state timeout is built only when GATE_TIMEOUT_EN is defined.
module gate_sensor_fsm #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic full,
  input  logic empty,
  output logic car_in,
  output logic car_out,
  output logic reject,
  output logic error,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, ERR
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_fin_in;
  logic   w_fin_out;
  logic   w_tmo;
  logic   r_car_in;
  logic   r_car_out;
  logic   r_reject;
  logic   r_error;

`ifdef GATE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_tmo = (r_cnt == TMO_LAST);

  // Counts only while parked in one in-progress state; any move restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_next != r_state || w_next == IDLE || w_next == ERR) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_fin_in  = 1'b0;
    w_fin_out = 1'b0;
    case (r_state)
      IDLE: case ({a, b})
        2'b10:   w_next = IN_A;
        2'b01:   w_next = OUT_B;
        2'b11:   w_next = ERR;
        default: w_next = IDLE;
      endcase
      IN_A: case ({a, b})
        2'b11:   w_next = IN_AB;
        2'b00:   w_next = IDLE;
        2'b01:   w_next = ERR;
        default: if (w_tmo) w_next = ERR;
      endcase
      IN_AB: case ({a, b})
        2'b01:   w_next = IN_B;
        2'b10:   w_next = IN_A;
        2'b00:   w_next = ERR;
        default: if (w_tmo) w_next = ERR;
      endcase
      IN_B: case ({a, b})
        2'b00: begin
          w_next   = IDLE;
          w_fin_in = 1'b1;
        end
        2'b11:   w_next = IN_AB;
        2'b10:   w_next = ERR;
        default: if (w_tmo) w_next = ERR;
      endcase
      OUT_B: case ({a, b})
        2'b11:   w_next = OUT_BA;
        2'b00:   w_next = IDLE;
        2'b10:   w_next = ERR;
        default: if (w_tmo) w_next = ERR;
      endcase
      OUT_BA: case ({a, b})
        2'b10:   w_next = OUT_A;
        2'b01:   w_next = OUT_B;
        2'b00:   w_next = ERR;
        default: if (w_tmo) w_next = ERR;
      endcase
      OUT_A: case ({a, b})
        2'b00: begin
          w_next    = IDLE;
          w_fin_out = 1'b1;
        end
        2'b11:   w_next = OUT_BA;
        2'b01:   w_next = ERR;
        default: if (w_tmo) w_next = ERR;
      endcase
      default: if ({a, b} == 2'b00) w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_car_in  <= 1'b0;
      r_car_out <= 1'b0;
      r_reject  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_car_in  <= w_fin_in & ~full;
      r_car_out <= w_fin_out & ~empty;
      r_reject  <= (w_fin_in & full) | (w_fin_out & empty);
      r_error   <= (w_next == ERR) && (r_state != ERR);
    end
  end

  assign car_in  = r_car_in;
  assign car_out = r_car_out;
  assign reject  = r_reject;
  assign error   = r_error;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_gate_sensor_fsm.sv
// tb/tb_gate_sensor_fsm.sv - scoreboard bench for gate_sensor_fsm
module tb_gate_sensor_fsm;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b0, b = 1'b0, full = 1'b0, empty = 1'b0;
  logic car_in, car_out, reject, error, busy;

  int n_vec = 0;
  int n_bad = 0;
  string cur_tag = "init";

  logic [4:0] exp_q[$];

  // Behavioural reference: direction plus phase (0 idle, 1 first beam, 2 both, 3 second beam, 4 error).
  int m_dir = 0;
  int m_ph  = 0;
  int m_cnt = 0;

  gate_sensor_fsm #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .full(full), .empty(empty),
    .car_in(car_in), .car_out(car_out), .reject(reject), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {car_in, car_out, reject, error, busy};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [%s] got=%0h exp=%0h", tag, cur_tag, got, exp);
    end
  endtask

  task automatic model(input logic ia, input logic ib, input logic f, input logic e,
                       output logic [4:0] exp);
    logic x, y, fin;
    int nph, ndir;
    x = (m_dir != 0) ? ib : ia;
    y = (m_dir != 0) ? ia : ib;
    nph = m_ph;
    ndir = m_dir;
    fin = 1'b0;
    case (m_ph)
      0: if (ia && ib) nph = 4;
         else if (ia) begin nph = 1; ndir = 0; end
         else if (ib) begin nph = 1; ndir = 1; end
      1: if (x && y) nph = 2; else if (!x && !y) nph = 0; else if (!x && y) nph = 4;
      2: if (!x && y) nph = 3; else if (x && !y) nph = 1; else if (!x && !y) nph = 4;
      3: if (!x && !y) begin nph = 0; fin = 1'b1; end
         else if (x && y) nph = 2; else if (x && !y) nph = 4;
      default: if (!ia && !ib) nph = 0;
    endcase
`ifdef GATE_TIMEOUT_EN
    if (m_ph >= 1 && m_ph <= 3 && nph == m_ph && m_cnt == T - 1) nph = 4;
`endif
    m_cnt = (nph >= 1 && nph <= 3 && nph == m_ph) ? m_cnt + 1 : 0;
    exp = {fin && ndir == 0 && !f,
           fin && ndir == 1 && !e,
           fin && ((ndir == 1) ? e : f),
           nph == 4 && m_ph != 4,
           nph != 0};
    m_ph = nph;
    m_dir = ndir;
  endtask

  task automatic pop_check();
    logic [4:0] got, exp;
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      got = outs();
      check_eq("outs", got, exp);
      check_eq("onehot", ($countones(got[4:1]) <= 1), 1);
    end
  endtask

  task automatic step(input logic ia, input logic ib, input logic f, input logic e);
    logic [4:0] exp;
    @(posedge clk);
    #1;
    pop_check();
    a = ia; b = ib; full = f; empty = e;
    model(ia, ib, f, e, exp);
    exp_q.push_back(exp);
  endtask

  task automatic do_reset(input int cycles, input logic ia, input logic ib);
    logic [4:0] exp;
    @(posedge clk);
    #1;
    pop_check();
    reset = 1'b1;
    a = ia; b = ib; full = 1'b0; empty = 1'b0;
    #1;
    check_eq("rst_async", outs(), 0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_eq("rst_hold", outs(), 0);
    end
    m_ph = 0; m_dir = 0; m_cnt = 0;
    #2;
    reset = 1'b0;
    model(ia, ib, 1'b0, 1'b0, exp);
    exp_q.push_back(exp);
  endtask

  task automatic seq(input string tag, input logic [1:0] ab[], input logic f, input logic e);
    cur_tag = tag;
    foreach (ab[i]) step(ab[i][1], ab[i][0], f, e);
  endtask

  initial begin
    #2;
    check_eq("rst_init", outs(), 0);
    do_reset(2, 1'b0, 1'b0);

    seq("entry_ok",     '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00}, 1'b0, 1'b0);
    seq("exit_empty",   '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00}, 1'b0, 1'b1);
    seq("entry_full",   '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00}, 1'b1, 1'b0);
    seq("exit_ok",      '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00}, 1'b0, 1'b0);
    seq("back2back",    '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01,
                          2'b11, 2'b10, 2'b00, 2'b00}, 1'b0, 1'b0);
    seq("reverse_out",  '{2'b10, 2'b11, 2'b10, 2'b00, 2'b00}, 1'b0, 1'b0);
    seq("err_cross",    '{2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00}, 1'b0, 1'b0);
    seq("err_idle11",   '{2'b11, 2'b11, 2'b00, 2'b00}, 1'b0, 1'b0);
    seq("reentry_ab",   '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00}, 1'b0, 1'b0);

    cur_tag = "rst_mid";
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset(2, 1'b1, 1'b0);
    seq("after_rst",    '{2'b11, 2'b01, 2'b00, 2'b00}, 1'b0, 1'b0);

    seq("timeout",      '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                          2'b00, 2'b00}, 1'b0, 1'b0);
    seq("timeout_ab",   '{2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11,
                          2'b11, 2'b11, 2'b11, 2'b00, 2'b00}, 1'b0, 1'b0);

    cur_tag = "random";
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end
    seq("drain", '{2'b00, 2'b00}, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    pop_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gate_sensor_fsm.md
GATE_SENSOR_FSM -- requirements
Module: gate_sensor_fsm

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: max cycles allowed in any single in-progress state before abort; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of the timeout counter; SHALL satisfy 2^CNT_W > TIMEOUT_CYCLES.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a  input  1  debounced level of outer gate sensor; 1 = beam blocked.
REQ-006 b  input  1  debounced level of inner gate sensor; 1 = beam blocked.
REQ-007 full  input  1  occupancy at maximum (count == 7) from the downstream counter.
REQ-008 empty  input  1  occupancy at zero (count == 0) from the downstream counter.
REQ-009 car_in  output  1  one-cycle pulse: a valid entry completed and was accepted.
REQ-010 car_out  output  1  one-cycle pulse: a valid exit completed and was accepted.
REQ-011 reject  output  1  one-cycle pulse: a valid passage completed but was blocked by full or empty.
REQ-012 error  output  1  one-cycle pulse on entry to state ERR.
REQ-013 busy  output  1  level: state is not IDLE.

Function
REQ-014 States SHALL be IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A and ERR; (a,b) is sampled at each rising edge.
REQ-015 IDLE: (1,0)->IN_A; (0,1)->OUT_B; (1,1)->ERR; (0,0) stays.
REQ-016 IN_A: (1,1)->IN_AB; (0,0)->IDLE with no pulse (car backed out); (0,1)->ERR; (1,0) stays.
REQ-017 IN_AB: (0,1)->IN_B; (1,0)->IN_A (reversal); (0,0)->ERR; (1,1) stays.
REQ-018 IN_B: (0,0)->IDLE and completes an entry; (1,1)->IN_AB; (1,0)->ERR; (0,1) stays.
REQ-019 OUT_B, OUT_BA and OUT_A SHALL mirror REQ-016..REQ-018 with the roles of a and b swapped; OUT_A with (0,0) completes an exit.
REQ-020 ERR: (0,0)->IDLE; any other value stays; no completion pulse SHALL come from ERR.
REQ-021 A completed entry SHALL assert car_in if full==0, else reject; full is sampled on the completing edge.
REQ-022 A completed exit SHALL assert car_out if empty==0, else reject; empty is sampled on the completing edge.
REQ-023 All outputs SHALL be registered; a pulse is high for exactly the one cycle after the clock edge that caused it (latency 1).
REQ-024 car_in, car_out, reject and error SHALL be mutually exclusive in every cycle.
REQ-025 Back-to-back passages SHALL be accepted with no dead cycle: IDLE may leave on the edge immediately after a completion.
REQ-026 busy SHALL be combinational on the state register and equal 1 in every state other than IDLE, ERR included.

Reset
REQ-027 While reset=1, state SHALL be IDLE, the timeout counter 0, and car_in, car_out, reject, error and busy 0, independent of clk.
REQ-028 Reset asserted mid-passage SHALL abandon the passage with no pulse; after release, the FSM restarts from IDLE on the next edge.
REQ-029 If a or b is high when reset releases, normal IDLE transition rules SHALL apply.

Configuration
REQ-030 Macro GATE_TIMEOUT_EN defined: in IN_*/OUT_* states, a CNT_W-bit counter increments each cycle and clears on every state change.
REQ-031 With GATE_TIMEOUT_EN, the FSM SHALL move to ERR and pulse error on the edge where the counter equals TIMEOUT_CYCLES-1 and no other transition is due.
REQ-032 Without GATE_TIMEOUT_EN, no counter SHALL be synthesised and in-progress states wait indefinitely.

Verification
REQ-033 (a,b) = 00,10,11,01,00, full=0 -> car_in=1 for exactly one cycle, one cycle after the final 00 edge; busy returns to 0.
REQ-034 (a,b) = 00,01,11,10,00, empty=1 -> reject=1 for one cycle, car_out stays 0.
REQ-035 (a,b) = 10,11,10,00 (reversal then back-out) -> no pulse; state returns to IDLE.
REQ-036 (a,b) = 10 then 01 -> error=1 for one cycle; busy stays 1 until 00 is applied, then 0.
REQ-037 With GATE_TIMEOUT_EN and TIMEOUT_CYCLES=4, hold (1,0) -> error pulses once 4 cycles after entering IN_A; reset pulsed during IN_AB -> all outputs 0 and no pulse.
